profile_counter_ci: RTL

PROFILE_COUNTER_CI -- requirements
Module: profile_counter_ci

---
 rtl/profile_counter_ci.sv | 129 ++++++++++++
 1 files changed

// File: rtl/profile_counter_ci.sv
// Event-profiling custom instruction: per-counter event counting with enable mask,
// sticky overflow flags, atomic snapshot shadows and a fixed one-cycle response.
module profile_counter_ci #(
  parameter logic [7:0]  customId      = 8'd8,
  parameter int          NUM_COUNTERS  = 4,
  parameter int          COUNTER_WIDTH = 32,
  parameter bit          SATURATE      = 1'b0,
  parameter logic [15:0] ENABLE_INIT   = 16'h0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              ciN,
  input  logic [31:0]             valueA,
  input  logic [31:0]             valueB,
  input  logic [NUM_COUNTERS-1:0] events,
  output logic                    done,
  output logic [31:0]             result
);

  localparam int NC = NUM_COUNTERS;
  localparam int CW = COUNTER_WIDTH;

  typedef enum logic [2:0] {
    OP_READ_LO  = 3'd0,
    OP_READ_HI  = 3'd1,
    OP_CONTROL  = 3'd2,
    OP_CLEAR    = 3'd3,
    OP_SNAPSHOT = 3'd4,
    OP_SNAP_LO  = 3'd5,
    OP_SNAP_HI  = 3'd6,
    OP_STATUS   = 3'd7
  } op_e;

  logic [NC-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NC-1:0][CW-1:0] shd_q, shd_d;
  logic [NC-1:0]         ovf_q, ovf_d;
  logic [NC-1:0]         en_q, en_d;
  logic                  done_q, done_d;
  logic [31:0]           result_q, result_d;

  logic        accept;
  op_e         op;
  logic [3:0]  idx;
  logic [63:0] cnt_sel, shd_sel;
  logic [31:0] res_sel;
  logic        unused_bits;

  assign accept      = start && (ciN == customId);
  assign op          = op_e'(valueA[2:0]);
  assign idx         = valueA[7:4];
  assign unused_bits = ^{valueA[31:8], valueA[3], valueB};

  // Out-of-range indices match no entry, so reads fall back to zero.
  always_comb begin
    cnt_sel = '0;
    shd_sel = '0;
    for (int i = 0; i < NC; i++) begin
      if (idx == 4'(i)) begin
        cnt_sel = 64'(cnt_q[i]);
        shd_sel = 64'(shd_q[i]);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    shd_d = shd_q;
    ovf_d = ovf_q;
    en_d  = en_q;
    if (accept && op == OP_STATUS && valueB[0]) ovf_d = '0;
    if (accept && op == OP_CONTROL)
      en_d = (en_q | valueB[NC-1:0]) & ~valueB[16+NC-1:16];
    if (accept && op == OP_SNAPSHOT) shd_d = cnt_q;
    // Clear beats a same-cycle increment; a same-cycle overflow survives a STATUS clear.
    for (int i = 0; i < NC; i++) begin
      if (accept && op == OP_CLEAR && valueB[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (en_q[i] && events[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_d[i] = 1'b1;
          if (!SATURATE) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    res_sel = '0;
    case (op)
      OP_READ_LO:  res_sel = cnt_sel[31:0];
      OP_READ_HI:  res_sel = cnt_sel[63:32];
      OP_CONTROL:  res_sel = 32'(en_q);
      OP_CLEAR:    res_sel = '0;
      OP_SNAPSHOT: res_sel = {16'd0, 16'(ovf_q)};
      OP_SNAP_LO:  res_sel = shd_sel[31:0];
      OP_SNAP_HI:  res_sel = shd_sel[63:32];
      OP_STATUS:   res_sel = {16'(ovf_q), 16'(en_q)};
      default:     res_sel = '0;
    endcase
    done_d   = accept;
    result_d = accept ? res_sel : 32'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      shd_q    <= '0;
      ovf_q    <= '0;
      en_q     <= ENABLE_INIT[NC-1:0];
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shd_q    <= shd_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
